// File: rtl/key_expand128_pkg.sv
// Shared AES-128 definitions: round count, key-schedule round constants and
// the key-expansion FSM state encoding.
package key_expand128_pkg;

    localparam int unsigned NR_DEFAULT = 10;

    typedef enum logic [1:0] {
        StIdle,
        StPresent,
        StLast
    } ke_state_e;

    // Round constant indexed by the round-key index being produced (1..10).
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sbox32.sv
// Four parallel AES forward S-boxes applied bytewise to a 32-bit word.
module sbox32 (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    // Byte 0x00 sits in the top eight bits; entry b lives at bit offset (255-b)*8.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SboxTable[base +: 8];
    endfunction

    always_comb begin
        word_o = {sub_byte(word_i[31:24]), sub_byte(word_i[23:16]),
                  sub_byte(word_i[15:8]),  sub_byte(word_i[7:0])};
    end

endmodule

// File: rtl/key_expand128.sv
// AES-128 key expansion: presents round keys 0..NR one at a time over a
// valid/ready handshake, holding only the current round key.
module key_expand128
    import key_expand128_pkg::*;
#(
    parameter int unsigned NR = NR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk,
    output logic         done
);

    localparam logic [3:0] LastIdx = 4'(NR);

    ke_state_e    state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   idx_q, idx_d;

    logic [31:0]  rot_w3, sub_w3, t_word;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [3:0]   next_idx;
    logic [127:0] next_key;

    assign rot_w3 = {rk_q[23:0], rk_q[31:24]};

    sbox32 u_sbox32 (
        .word_i (rot_w3),
        .word_o (sub_w3)
    );

    always_comb begin
        next_idx = idx_q + 4'd1;
        t_word   = sub_w3 ^ {rcon(next_idx), 24'h0};
        w0_n     = rk_q[127:96] ^ t_word;
        w1_n     = rk_q[95:64]  ^ w0_n;
        w2_n     = rk_q[63:32]  ^ w1_n;
        w3_n     = rk_q[31:0]   ^ w2_n;
        next_key = {w0_n, w1_n, w2_n, w3_n};
    end

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                // rk_ready is meaningless here; only start is looked at.
                if (start) begin
                    rk_d    = key_in;
                    idx_d   = 4'd0;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (rk_ready) begin
                    rk_d    = next_key;
                    idx_d   = next_idx;
                    state_d = (next_idx == LastIdx) ? StLast : StPresent;
                end
            end
            StLast: begin
                if (rk_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rk_q    <= 128'h0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign rk_valid = busy;
    assign rk_idx   = idx_q;
    assign rk       = rk_q;
    // Acceptance of the final key is only known in the cycle it happens.
    assign done     = (state_q == StLast) && rk_ready;

endmodule
